// File: rtl/countdown_processor.sv
// countdown_processor: four-state controller plus x/y datapath that loads, forms a step, then adds the step to x until x matches imm.
module countdown_processor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, add_a, add_b, sum;
  logic eq;
  always_comb begin
    state_d = state_q == S0 ? S1 : state_q == S1 ? S2 : S3;
  end
  // One shared adder: y+imm while forming the step, x+y while counting.
  assign add_a = state_q == S2 ? y_q : x_q;
  assign add_b = state_q == S2 ? imm : y_q;
  assign sum   = add_a + add_b;
  assign eq    = x_q == imm;
  always_comb begin
    x_d = state_q == S0 ? imm : (state_q == S3 && !eq) ? sum : x_q;
    y_d = state_q == S1 ? imm : state_q == S2 ? sum : y_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
endmodule

// File: tb/tb_countdown_processor.sv
// tb_countdown_processor: directed vectors with hand-computed x/y expectations.
module tb_countdown_processor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] imm = 4'h0;
  logic [3:0] x, y;
  int vectors = 0;
  int errs = 0;

  countdown_processor #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .imm(imm), .x(x), .y(y));

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] v);
    @(negedge clk);
    reset = r;
    imm = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_xy(input string tag, input logic [3:0] ex, input logic [3:0] ey);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
  endtask

  initial begin
    logic [3:0] e;
    step(1, 4'h7); chk_xy("reset1", 4'h0, 4'h0);
    step(1, 4'h7); chk_xy("reset2", 4'h0, 4'h0);
    step(0, 4'h2); chk_xy("nom_s0", 4'h2, 4'h0);
    step(0, 4'h0); chk_xy("nom_s1", 4'h2, 4'h0);
    step(0, 4'hF); chk_xy("nom_s2", 4'h2, 4'hF);
    step(0, 4'h0); chk_xy("nom_c1", 4'h1, 4'hF);
    step(0, 4'h0); chk_xy("nom_c2", 4'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0); chk_xy("nom_hold", 4'h0, 4'hF);
    end
    step(1, 4'h0); chk_xy("rst_a", 4'h0, 4'h0);
    step(0, 4'h2); chk_xy("mid_s0", 4'h2, 4'h0);
    step(0, 4'h0); chk_xy("mid_s1", 4'h2, 4'h0);
    step(0, 4'hF); chk_xy("mid_s2", 4'h2, 4'hF);
    step(0, 4'h0); chk_xy("mid_c1", 4'h1, 4'hF);
    step(1, 4'h0); chk_xy("mid_rst", 4'h0, 4'h0);
    step(0, 4'h2); chk_xy("mid2_s0", 4'h2, 4'h0);
    step(0, 4'h0); chk_xy("mid2_s1", 4'h2, 4'h0);
    step(0, 4'hF); chk_xy("mid2_s2", 4'h2, 4'hF);
    step(0, 4'h0); chk_xy("mid2_c1", 4'h1, 4'hF);
    step(0, 4'h0); chk_xy("mid2_c2", 4'h0, 4'hF);
    step(1, 4'h0); chk_xy("rst_b", 4'h0, 4'h0);
    step(0, 4'h0); chk_xy("wrap_s0", 4'h0, 4'h0);
    step(0, 4'h0); chk_xy("wrap_s1", 4'h0, 4'h0);
    step(0, 4'hF); chk_xy("wrap_s2", 4'h0, 4'hF);
    e = 4'hF;
    for (int i = 0; i < 13; i++) begin
      step(0, 4'h3); chk_xy("wrap_cnt", e, 4'hF);
      e = e - 4'h1;
    end
    step(0, 4'h3); chk_xy("wrap_hold1", 4'h3, 4'hF);
    step(0, 4'h3); chk_xy("wrap_hold2", 4'h3, 4'hF);
    step(1, 4'h0); chk_xy("rst_c", 4'h0, 4'h0);
    step(0, 4'h4); chk_xy("zero_s0", 4'h4, 4'h0);
    step(0, 4'h0); chk_xy("zero_s1", 4'h4, 4'h0);
    step(0, 4'h0); chk_xy("zero_s2", 4'h4, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h1); chk_xy("zero_stuck", 4'h4, 4'h0);
    end
    step(1, 4'h0); chk_xy("rst_d", 4'h0, 4'h0);
    step(0, 4'h5); chk_xy("eq_s0", 4'h5, 4'h0);
    step(0, 4'h0); chk_xy("eq_s1", 4'h5, 4'h0);
    step(0, 4'h1); chk_xy("eq_s2", 4'h5, 4'h1);
    step(0, 4'h5); chk_xy("eq_c1", 4'h5, 4'h1);
    step(0, 4'h5); chk_xy("eq_c2", 4'h5, 4'h1);
    step(0, 4'h7); chk_xy("imm_chg1", 4'h6, 4'h1);
    step(0, 4'h7); chk_xy("imm_chg2", 4'h7, 4'h1);
    step(0, 4'h7); chk_xy("imm_chg3", 4'h7, 4'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
